// File: rtl/mux_large_arbiter.sv
// Round-robin owner of the 10:1 block mux select: grants one requester at a time,
// captures up to BURST_MAX beats per grant and hands them downstream over valid/ready.
module mux_large_arbiter #(
  parameter int N_REQ     = 10,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [3:0]       sel,
  input  logic [DW-1:0]    mux_data,
  output logic [N_REQ-1:0] ack,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [3:0] LAST_RST  = 4'(N_REQ - 1);
  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_t     state, state_nxt;
  logic [3:0] owner, owner_nxt;
  logic [3:0] last, last_nxt;
  logic [3:0] beat_cnt, beat_cnt_nxt;
  logic       cap;
  logic       found;
  logic [3:0] winner;
  logic [4:0] cand;

  // A beat is taken only when the output register is empty or being drained this cycle.
  assign cap  = (state == XFER) && req[owner] && (!out_valid || out_ready);
  assign sel  = owner;
  assign busy = (state == XFER);

  // Scan from farthest to nearest so the requester closest after `last` wins.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    found  = 1'b0;
    winner = last;
    cand   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = {1'b0, last} + 5'(i);
      if (cand >= 5'(N_REQ)) cand = cand - 5'(N_REQ);
      if (req[cand[3:0]]) begin
        found  = 1'b1;
        winner = cand[3:0];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    last_nxt     = last;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt    = winner;
          beat_cnt_nxt = '0;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        if (!req[owner]) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end else if (cap) begin
          beat_cnt_nxt = beat_cnt + 4'd1;
          if (beat_cnt + 4'd1 == BURST_LIM) begin
            state_nxt = IDLE;
            last_nxt  = owner;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (cap) ack[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= LAST_RST;
      beat_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state    <= state_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Capture wins over drain, so a simultaneous consume+capture keeps valid high with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_large_arbiter.sv
// Bench for mux_large_arbiter: emulates the block mux and ten requesters, and compares
// every cycle against a transaction-level reference of the round-robin burst rules.
module tb_mux_large_arbiter;

  localparam int N_REQ     = 10;
  localparam int DW        = 8;
  localparam int BURST_MAX = 4;

  logic             clk;
  logic             rst_n;
  logic [N_REQ-1:0] req;
  logic [3:0]       sel;
  logic [DW-1:0]    mux_data;
  logic [N_REQ-1:0] ack;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Requester blocks as seen through the mux.
  logic [DW-1:0] blk [N_REQ];
  bit            rnd_mode = 1'b0;
  assign mux_data = (sel < 4'd10) ? blk[sel] : 8'h00;

  // Reference: a grant is an owner plus the number of beats it may still deliver.
  bit         m_busy;
  logic [3:0] m_owner;
  logic [3:0] m_last;
  int         m_left;
  bit         m_valid;
  logic [7:0] m_data;

  // Observations taken from the DUT for directed end-of-test checks.
  logic [3:0] grants[$];
  logic [7:0] consumed[$];
  int         acks;
  bit         prev_busy;

  mux_large_arbiter #(
    .N_REQ    (N_REQ),
    .DW       (DW),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .sel      (sel),
    .mux_data (mux_data),
    .ack      (ack),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pick(input logic [3:0] from, input logic [9:0] r);
    for (int k = 1; k <= N_REQ; k++) begin
      if (r[4'((int'(from) + k) % N_REQ)]) return 4'((int'(from) + k) % N_REQ);
    end
    return 4'hF;
  endfunction

  function automatic logic [3:0] grant_at(input int idx);
    if (idx < grants.size()) return grants[idx];
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 4'd0;
    m_last  = 4'd9;
    m_left  = 0;
    m_valid = 1'b0;
    m_data  = 8'h00;
  endtask

  task automatic clear_logs();
    grants.delete();
    consumed.delete();
    acks      = 0;
    prev_busy = 1'b0;
  endtask

  // One clock: called just after a falling edge with inputs already applied.
  task automatic step();
    bit         cap;
    logic [3:0] cap_owner;
    logic [9:0] exp_ack;
    #1;
    cap       = m_busy && req[m_owner] && (!m_valid || out_ready);
    cap_owner = m_owner;
    exp_ack   = cap ? (10'd1 << m_owner) : 10'd0;
    check("sel", sel, m_owner);
    check("busy", busy, m_busy);
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("ack", ack, exp_ack);

    if (busy && !prev_busy) grants.push_back(sel);
    prev_busy = busy;
    acks += $countones(ack);
    if (out_valid && out_ready) consumed.push_back(out_data);

    if (cap) begin
      m_data  = blk[cap_owner];
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (!m_busy) begin
      if (req != 10'd0) begin
        m_owner = pick(m_last, req);
        m_busy  = 1'b1;
        m_left  = BURST_MAX;
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (cap) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end

    @(posedge clk);
    @(negedge clk);
    if (cap) blk[cap_owner] = rnd_mode ? 8'($urandom) : blk[cap_owner] + 8'd1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) blk[i] = 8'(i * 16);
    model_reset();
    clear_logs();
    @(negedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset with no requests.
    repeat (20) step();
    check("idle_grants", grants.size(), 0);

    // Single three-beat burst from requester 2.
    apply_reset();
    blk[2] = 8'h10;
    req    = 10'h004;
    repeat (4) step();
    req = 10'h000;
    repeat (2) step();
    check("single_acks", acks, 3);
    check("single_n", consumed.size(), 3);
    check("single_d0", consumed.size() > 0 ? consumed[0] : 8'hxx, 8'h10);
    check("single_d1", consumed.size() > 1 ? consumed[1] : 8'hxx, 8'h11);
    check("single_d2", consumed.size() > 2 ? consumed[2] : 8'hxx, 8'h12);
    check("single_g0", grant_at(0), 2);
    // last is now 2, so requester 3 beats requester 1.
    req = 10'h00A;
    repeat (2) step();
    check("after_last2", grant_at(1), 3);
    req = 10'h000;
    repeat (6) step();

    // Burst cap and rotation between requesters 0 and 5.
    apply_reset();
    req = 10'h021;
    repeat (20) step();
    req = 10'h000;
    repeat (2) step();
    check("rot_n", grants.size(), 4);
    check("rot_g0", grant_at(0), 0);
    check("rot_g1", grant_at(1), 5);
    check("rot_g2", grant_at(2), 0);
    check("rot_g3", grant_at(3), 5);
    check("rot_acks", acks, 16);

    // Wrap-around: leave last at 9, then 0 must precede 9.
    apply_reset();
    req = 10'h200;
    repeat (2) step();
    req = 10'h000;
    step();
    req = 10'h201;
    repeat (7) step();
    req = 10'h000;
    repeat (6) step();
    check("wrap_g1", grant_at(1), 0);
    check("wrap_g2", grant_at(2), 9);

    // Backpressure mid-burst.
    begin
      int            acks_before;
      logic [DW-1:0] held;
      apply_reset();
      req = 10'h008;
      repeat (3) step();
      out_ready   = 1'b0;
      acks_before = acks;
      held        = out_data;
      repeat (5) step();
      check("bp_acks_hold", acks, acks_before);
      check("bp_data_hold", out_data, held);
      out_ready = 1'b1;
      for (int k = 0; k < 20 && busy; k++) step();
      check("bp_done", busy, 0);
      check("bp_total", acks, BURST_MAX);
      req = 10'h000;
      repeat (2) step();
    end

    // Reset in the middle of a burst.
    apply_reset();
    req = 10'h010;
    repeat (3) step();
    check("mid_valid_pre", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_valid_rst", out_valid, 0);
    check("mid_busy_rst", busy, 0);
    check("mid_sel_rst", sel, 0);
    check("mid_ack_rst", ack, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    req = 10'h011;
    repeat (2) step();
    check("mid_restart", grant_at(0), 0);
    req = 10'h000;
    repeat (8) step();

    // Randomized traffic with random backpressure.
    apply_reset();
    rnd_mode = 1'b1;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(3) == 0) req[i] = ~req[i];
      end
      out_ready = ($urandom_range(9) < 7);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_large_arbiter.md
# mux_large_arbiter

Round-robin controller that shares the 10-input, 8-bit block mux between ten requesters. It drives the mux select, captures the selected block into a one-entry output register, and delivers it downstream over a valid/ready handshake. Each owner may stream a bounded burst of beats before the grant rotates. It sits directly in front of the `mux_large` datapath instance and owns its `sel` input.

## Interface

- `N_REQ`, 10: number of requesters; fixed by mux width, not to be overridden.
- `DW`, 8: data width of the mux output.
- `BURST_MAX`, 4: maximum beats per grant; legal range 1–15.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `req`  in  10: level request per requester; bit i is block a..j in order.
- `sel`  out  4: mux select; encodes the current owner 0–9.
- `mux_data`  in  DW: combinational return from the mux output.
- `ack`  out  10: one-cycle pulse; bit i means requester i's current block was captured this cycle.
- `out_data`  out  DW: registered output block.
- `out_valid`  out  1: `out_data` holds an unconsumed beat.
- `out_ready`  in  1: downstream accepts the beat when `out_valid` and `out_ready` are both high.
- `busy`  out  1: FSM is in XFER.

## Operation

- FSM states:
  - **IDLE**: arbitrate.
  - **XFER**: stream beats from the owner.
- Round-robin pointer `last` resets to 9, so requester 0 has first priority.
- **IDLE**:
  - If `req` is nonzero, owner = first set bit searching `last+1, last+2, …` with wrap 9→0.
  - Load owner, clear `beat_cnt`, go to XFER.
  - If `req` is zero, stay in IDLE.
- `sel` = owner register, at all times.
  - In IDLE it holds the previous owner.
  - Reset value is 0.
- **XFER**, per cycle:
  - `cap` = `req[owner]` & (`!out_valid` | `out_ready`).
  - On `cap`:
    - `out_data` ← `mux_data`, `out_valid` ← 1.
    - `ack[owner]` = 1 that cycle.
    - `beat_cnt` increments.
  - If `out_valid & out_ready & !cap`: `out_valid` ← 0.
  - Exit to IDLE, with `last` ← owner, when either condition holds:
    - `req[owner]` is low; no capture happens that cycle.
    - `cap` and `beat_cnt+1 == BURST_MAX`.
- `ack` is decoded from the registered owner and `cap`. At most one bit is set, and never in IDLE.
- A requester must present its next block on the cycle after its `ack` bit, or drop `req`.
- Backpressure:
  - While `out_valid & !out_ready`, there is no capture and no `ack`.
  - `beat_cnt` and owner hold.
  - Stall length is unbounded.
- `beat_cnt` counts captures only, never stall cycles. Width is 4 bits.
- `out_valid` stays set across the XFER→IDLE transition until consumed.
- `BURST_MAX` = 1 gives pure per-beat round robin.

## Timing

- Reset values (asynchronous, on `rst_n` low):
  - `state` = IDLE, `last` = 9, owner/`sel` = 0, `beat_cnt` = 0.
  - `out_valid` = 0, `out_data` = 0, `ack` = 0, `busy` = 0.
- Assertion of `rst_n` mid-burst discards the in-flight beat. No `ack` is issued on the reset cycle.
- Latency:
  - `req` rises in IDLE at cycle t → XFER with new `sel` at t+1.
  - First capture/`ack` at t+1; `out_valid` high at t+2.
- Throughput in XFER with `out_ready` held high: 1 beat/cycle.
- Arbitration bubble: one IDLE cycle between grants. No capture occurs in IDLE.
- `mux_data` is sampled in the same cycle `sel` is driven. The mux path is combinational, so there is no pipeline stage.
- `req` changes are observed only at clock edges. A request raised in XFER by a non-owner waits for the next IDLE.
- Simultaneous events:
  - Consume and capture in the same cycle: `out_valid` stays 1 and data is replaced.
  - Owner `req` drop coinciding with a stall: exit to IDLE, no `ack`.

## Test plan

- Reset/idle: hold `rst_n` = 0, then release with `req` = 0 → all outputs at reset values, `busy` = 0, `sel` = 0 for 20 cycles.
- Single burst: `req[2]` high for 3 beats, `mux_data` = 0x10, 0x11, 0x12, `out_ready` = 1 → `sel` = 2; `ack[2]` pulses on 3 consecutive cycles; `out_data` 0x10, 0x11, 0x12 with `out_valid` on consecutive cycles; then IDLE with `last` = 2.
- Burst cap and rotation: `req[0]` and `req[5]` held high, `BURST_MAX` = 4 → grant order 0,5,0,5 with 4 beats each and one bubble cycle between grants.
- Wrap-around: `last` = 9 via a grant to requester 9, then `req` = 0x201 → requester 0 is granted before requester 9.
- Backpressure: during a burst, `out_ready` low for 5 cycles → `out_data` is stable, no `ack`, `beat_cnt` holds; the burst resumes on release and totals still equal `BURST_MAX`.
- Reset mid-burst: assert `rst_n` low after the 2nd beat → `out_valid` = 0 immediately; after release, arbitration restarts from requester 0.
